// File: rtl/nanorv32_pmux_porta_if.sv
// nanorv32_pmux_porta_if: word-wide register access port for the port A pin mux
interface nanorv32_pmux_porta_if;
    logic        bus_sel;
    logic        bus_we;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    modport master (output bus_sel, bus_we, bus_addr, bus_wdata, input bus_rdata);
    modport slave (input bus_sel, bus_we, bus_addr, bus_wdata, output bus_rdata);
endinterface

// File: rtl/nanorv32_pmux_porta.sv
// nanorv32_pmux_porta: port A pin mux, GPIO registers, 2-flop input sync and edge interrupts
module nanorv32_pmux_porta #(
    parameter int CHIP_PORT_A_WIDTH = 16
) (
    input  logic                         clk_in,
    input  logic                         rst,
    nanorv32_pmux_porta_if.slave         bus,
    output logic [CHIP_PORT_A_WIDTH-1:0] pmux_pad_dout,
    output logic [CHIP_PORT_A_WIDTH-1:0] pmux_pad_oe,
    output logic [CHIP_PORT_A_WIDTH-1:0] pmux_pad_ie,
    input  logic [CHIP_PORT_A_WIDTH-1:0] pad_pmux_din,
    input  logic [CHIP_PORT_A_WIDTH-1:0] af_dout,
    input  logic [CHIP_PORT_A_WIDTH-1:0] af_oe,
    input  logic [CHIP_PORT_A_WIDTH-1:0] af_ie,
    output logic [CHIP_PORT_A_WIDTH-1:0] af_din,
    output logic                         gpio_irq
);
    localparam int W = CHIP_PORT_A_WIDTH;
    logic [W-1:0] dout_r, oe_r, afsel_r, rise_en_r, fall_en_r, irq_status_r;
    logic [W-1:0] sync1, sync2, prev, rise, fall, w1c, wd, rd_w;
    logic [2:0]   idx;
    logic         wr, rd, unused_bits;
    assign idx = bus.bus_addr[4:2];
    assign wr = bus.bus_sel & bus.bus_we;
    assign rd = bus.bus_sel & ~bus.bus_we;
    assign wd = bus.bus_wdata[W-1:0];
    assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata};
    assign rise = sync2 & ~prev & rise_en_r;
    assign fall = ~sync2 & prev & fall_en_r;
    assign w1c = (wr && idx == 3'd6) ? wd : '0;
    assign rd_w = idx == 3'd0 ? dout_r :
                  idx == 3'd1 ? oe_r :
                  idx == 3'd2 ? sync2 :
                  idx == 3'd3 ? afsel_r :
                  idx == 3'd4 ? rise_en_r :
                  idx == 3'd5 ? fall_en_r :
                  idx == 3'd6 ? irq_status_r : '0;
    assign pmux_pad_dout = (afsel_r & af_dout) | (~afsel_r & dout_r);
    assign pmux_pad_oe = (afsel_r & af_oe) | (~afsel_r & oe_r);
    assign pmux_pad_ie = (afsel_r & af_ie) | ~afsel_r;
    assign af_din = sync2;
    assign gpio_irq = |irq_status_r;
    always_ff @(posedge clk_in) begin
        if (rst) begin
            dout_r <= '0;
            oe_r <= '0;
            afsel_r <= '0;
            rise_en_r <= '0;
            fall_en_r <= '0;
            irq_status_r <= '0;
            sync1 <= '0;
            sync2 <= '0;
            prev <= '0;
            bus.bus_rdata <= '0;
        end else begin
            sync1 <= pad_pmux_din;
            sync2 <= sync1;
            prev <= sync2;
            irq_status_r <= (irq_status_r & ~w1c) | rise | fall;
            dout_r <= (wr && idx == 3'd0) ? wd : dout_r;
            oe_r <= (wr && idx == 3'd1) ? wd : oe_r;
            afsel_r <= (wr && idx == 3'd3) ? wd : afsel_r;
            rise_en_r <= (wr && idx == 3'd4) ? wd : rise_en_r;
            fall_en_r <= (wr && idx == 3'd5) ? wd : fall_en_r;
            bus.bus_rdata <= rd ? 32'(rd_w) : bus.bus_rdata;
        end
    end
endmodule

// File: tb/tb_nanorv32_pmux_porta.sv
// tb_nanorv32_pmux_porta: directed-vector self-checking bench for the port A pin mux
module tb_nanorv32_pmux_porta;
    localparam int W = 16;
    logic         clk_in = 1'b0;
    logic         rst;
    logic [W-1:0] pmux_pad_dout, pmux_pad_oe, pmux_pad_ie, af_din;
    logic [W-1:0] pad_pmux_din, af_dout, af_oe, af_ie;
    logic         gpio_irq;
    logic [31:0]  rd_data;
    int           n_vec = 0;
    int           n_bad = 0;
    nanorv32_pmux_porta_if bus_if ();
    nanorv32_pmux_porta #(.CHIP_PORT_A_WIDTH(W)) dut (
        .clk_in(clk_in),
        .rst(rst),
        .bus(bus_if),
        .pmux_pad_dout(pmux_pad_dout),
        .pmux_pad_oe(pmux_pad_oe),
        .pmux_pad_ie(pmux_pad_ie),
        .pad_pmux_din(pad_pmux_din),
        .af_dout(af_dout),
        .af_oe(af_oe),
        .af_ie(af_ie),
        .af_din(af_din),
        .gpio_irq(gpio_irq)
    );
    always #5 clk_in = ~clk_in;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(posedge clk_in);
        #1;
    endtask
    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        bus_if.bus_sel = 1'b1;
        bus_if.bus_we = 1'b1;
        bus_if.bus_addr = a;
        bus_if.bus_wdata = d;
        tick(1);
        bus_if.bus_sel = 1'b0;
        bus_if.bus_we = 1'b0;
    endtask
    task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
        bus_if.bus_sel = 1'b1;
        bus_if.bus_we = 1'b0;
        bus_if.bus_addr = a;
        tick(1);
        bus_if.bus_sel = 1'b0;
        d = bus_if.bus_rdata;
    endtask
    initial begin
        rst = 1'b1;
        bus_if.bus_sel = 1'b0;
        bus_if.bus_we = 1'b0;
        bus_if.bus_addr = '0;
        bus_if.bus_wdata = '0;
        pad_pmux_din = '0;
        af_dout = '0;
        af_oe = '0;
        af_ie = '0;
        tick(1);
        rst = 1'b0;
        chk("rst_dout", 32'(pmux_pad_dout), 32'h0);
        chk("rst_oe", 32'(pmux_pad_oe), 32'h0);
        chk("rst_ie", 32'(pmux_pad_ie), 32'hFFFF);
        chk("rst_irq", 32'(gpio_irq), 32'h0);
        chk("rst_afdin", 32'(af_din), 32'h0);
        chk("rst_rdata", bus_if.bus_rdata, 32'h0);
        for (int r = 0; r < 8; r++) begin
            bus_rd(5'(r * 4), rd_data);
            chk($sformatf("rst_reg%0d", r), rd_data, 32'h0);
        end
        bus_wr(5'h04, 32'h00FF);
        bus_wr(5'h00, 32'h00A5);
        chk("gpio_oe", 32'(pmux_pad_oe), 32'h00FF);
        chk("gpio_dout", 32'(pmux_pad_dout), 32'h00A5);
        bus_rd(5'h04, rd_data);
        chk("rb_oe", rd_data, 32'h00FF);
        bus_rd(5'h00, rd_data);
        chk("rb_dout", rd_data, 32'h00A5);
        af_dout = 16'h0002;
        af_oe = 16'h0003;
        af_ie = 16'h0000;
        bus_wr(5'h0C, 32'h0003);
        chk("af_dout", 32'(pmux_pad_dout), 32'h00A6);
        chk("af_oe", 32'(pmux_pad_oe), 32'h00FF);
        chk("af_ie", 32'(pmux_pad_ie), 32'hFFFC);
        bus_rd(5'h0C, rd_data);
        chk("rb_afsel", rd_data, 32'h0003);
        bus_wr(5'h10, 32'h0010);
        pad_pmux_din = 16'h0010;
        tick(1);
        chk("din_e1", 32'(af_din), 32'h0);
        tick(1);
        chk("din_e2", 32'(af_din), 32'h0010);
        chk("irq_e2", 32'(gpio_irq), 32'h0);
        tick(1);
        chk("irq_e3", 32'(gpio_irq), 32'h1);
        bus_rd(5'h18, rd_data);
        chk("status_rise", rd_data, 32'h0010);
        bus_rd(5'h08, rd_data);
        chk("rb_din", rd_data, 32'h0010);
        bus_wr(5'h18, 32'h0010);
        chk("w1c_irq", 32'(gpio_irq), 32'h0);
        pad_pmux_din = 16'h0000;
        tick(4);
        chk("nofall_irq", 32'(gpio_irq), 32'h0);
        bus_rd(5'h18, rd_data);
        chk("nofall_status", rd_data, 32'h0);
        pad_pmux_din = 16'h0010;
        tick(2);
        bus_wr(5'h18, 32'h0010);
        chk("collide_irq", 32'(gpio_irq), 32'h1);
        bus_rd(5'h18, rd_data);
        chk("collide_status", rd_data, 32'h0010);
        bus_wr(5'h18, 32'h0010);
        chk("clear_irq", 32'(gpio_irq), 32'h0);
        bus_wr(5'h1C, 32'hFFFFFFFF);
        bus_wr(5'h08, 32'hFFFFFFFF);
        bus_rd(5'h1C, rd_data);
        chk("rsv_read", rd_data, 32'h0);
        bus_rd(5'h08, rd_data);
        chk("din_ro", rd_data, 32'h0010);
        chk("rsv_dout", 32'(pmux_pad_dout), 32'h00A6);
        chk("rsv_oe", 32'(pmux_pad_oe), 32'h00FF);
        bus_rd(5'h10, rd_data);
        chk("rsv_rise_en", rd_data, 32'h0010);
        chk("rsv_irq", 32'(gpio_irq), 32'h0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_dout", 32'(pmux_pad_dout), 32'h0);
        chk("mid_rst_oe", 32'(pmux_pad_oe), 32'h0);
        chk("mid_rst_ie", 32'(pmux_pad_ie), 32'hFFFF);
        chk("mid_rst_afdin", 32'(af_din), 32'h0);
        chk("mid_rst_rdata", bus_if.bus_rdata, 32'h0);
        bus_wr(5'h14, 32'h0010);
        tick(3);
        chk("fall_idle_irq", 32'(gpio_irq), 32'h0);
        pad_pmux_din = 16'h0000;
        tick(2);
        chk("fall_e2", 32'(gpio_irq), 32'h0);
        tick(1);
        chk("fall_e3", 32'(gpio_irq), 32'h1);
        bus_rd(5'h18, rd_data);
        chk("fall_status", rd_data, 32'h0010);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
